// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pkg                                                      |
// | Description : Shared types and helpers for the FFT output reorder path:    |
// |               read-side FSM state encoding, default sample type and a      |
// |               width-programmable bit-reversal function.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_pkg;

  // Default configuration; instantiating modules carry their own parameters.
  localparam int c_total_stage_def = 10;
  localparam int c_mult_width_def  = 18;

  // One complex sample {re, im} at the default component width.
  typedef logic [2*c_mult_width_def-1:0] sample_t;

  // Read-side FSM states.
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  // Reverse the low 'width' bits of v (width in 1..32); upper bits return 0.
  // Full 32-bit reversal followed by a right shift keeps the loop bounds fixed.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r >> (32 - width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_reorder_ram                                              |
// | Description : Simple dual-port RAM, one write port and one read port,      |
// |               registered read data (read latency 1).                       |
// | Ports       : clk, rst      - clock, async active-high reset (read reg)    |
// |               i_we/i_waddr/i_wdata - write port                            |
// |               i_re/i_raddr  - read request                                 |
// |               o_rdata       - read data, valid one edge after i_re         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_reorder_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Array itself is not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register is reset so the downstream data bus idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_reorder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_reorder_ctrl                                             |
// | Description : Ping-pong reorder controller. Frames arriving in bit-        |
// |               reversed order are written to one bank at bit-reversed       |
// |               addresses while the other bank is read out in natural        |
// |               order. Owns bank arbitration, frame counting and input       |
// |               backpressure.                                                |
// | Ports       : clk, rst           - clock, async active-high reset          |
// |               ien, idata, iready - input stream (transfer = ien & iready)  |
// |               ibypass            - per-frame arrival-order pass-through    |
// |                                    (only with FFT_REORDER_BYPASS_EN)       |
// |               oen, oaddr, odata  - output stream, natural-order bins       |
// |               osof               - marks bin 0 of each output frame        |
// | Config      : `define FFT_REORDER_BYPASS_EN adds the ibypass input.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_reorder_ctrl
  import fft_pkg::*;
#(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ien,
  input  logic [2*MULT_WIDTH_P-1:0] idata,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic                      ibypass,
`endif
  output logic                      iready,
  output logic                      oen,
  output logic [TOTAL_STAGE_P-1:0]  oaddr,
  output logic [2*MULT_WIDTH_P-1:0] odata,
  output logic                      osof
);

  // ---------------- registers ----------------
  logic [TOTAL_STAGE_P-1:0] r_wcnt;
  logic                     r_wsel;
  logic [1:0]               r_full;
  logic [TOTAL_STAGE_P-1:0] r_rcnt;
  logic                     r_rsel;
  rd_state_t                r_state;
  logic                     r_oen;
  logic [TOTAL_STAGE_P-1:0] r_oaddr;
  logic                     r_osof;

  // ---------------- combinational ----------------
  logic                     w_xfer;
  logic                     w_wlast;
  logic                     w_run;
  logic                     w_rlast;
  logic [TOTAL_STAGE_P-1:0] w_rev;
  logic [TOTAL_STAGE_P-1:0] w_waddr;
  logic [1:0]               w_full_nxt;

  assign iready  = ~r_full[r_wsel];
  assign w_xfer  = ien & iready;
  assign w_wlast = w_xfer & (r_wcnt == '1);
  assign w_run   = (r_state == R_RUN);
  assign w_rlast = w_run & (r_rcnt == '1);
  assign w_rev   = TOTAL_STAGE_P'(bitrev(32'(r_wcnt), TOTAL_STAGE_P));

`ifdef FFT_REORDER_BYPASS_EN
  logic r_byp;
  logic w_byp;

  // The first sample of a frame sees ibypass directly; later samples use the
  // value captured on that first transfer.
  assign w_byp   = (r_wcnt == '0) ? ibypass : r_byp;
  assign w_waddr = w_byp ? r_wcnt : w_rev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp <= 1'b0;
    end else if (w_xfer && (r_wcnt == '0)) begin
      r_byp <= ibypass;
    end
  end
`else
  assign w_waddr = w_rev;
`endif

  // Writer sets and reader clears always target different banks (the writer
  // only fills an empty bank, the reader only drains a full one), so both
  // updates are merged into one next-state value.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rlast) begin
      w_full_nxt[r_rsel] = 1'b0;
    end
    if (w_wlast) begin
      w_full_nxt[r_wsel] = 1'b1;
    end
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_xfer) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_wlast) begin
          r_wsel <= ~r_wsel;
        end
      end
    end
  end

  // ---------------- read-side FSM and output stage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_rcnt  <= '0;
      r_rsel  <= 1'b0;
      r_oen   <= 1'b0;
      r_oaddr <= '0;
      r_osof  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_full[r_rsel]) begin
            r_state <= R_RUN;
            r_rcnt  <= '0;
          end
        end
        R_RUN: begin
          r_rcnt <= r_rcnt + 1'b1;
          if (w_rlast) begin
            r_rsel <= ~r_rsel;
            // Other bank already complete: continue without a gap.
            if (!r_full[~r_rsel]) begin
              r_state <= R_IDLE;
            end
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase

      // Delay by one edge to line up with the registered RAM read data.
      r_oen   <= w_run;
      r_oaddr <= r_rcnt;
      r_osof  <= w_run & (r_rcnt == '0);
    end
  end

  assign oen   = r_oen;
  assign oaddr = r_oaddr;
  assign osof  = r_osof;

  fft_reorder_ram #(
    .ADDR_W (TOTAL_STAGE_P + 1),
    .DATA_W (2*MULT_WIDTH_P)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_xfer),
    .i_waddr ({r_wsel, w_waddr}),
    .i_wdata (idata),
    .i_re    (w_run),
    .i_raddr ({r_rsel, r_rcnt}),
    .o_rdata (odata)
  );

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_reorder_ctrl                                          |
// | Description : Self-checking bench for fft_reorder_ctrl at N=3. Accepted    |
// |               input samples build frames in a reference model; completed  |
// |               frames push their natural-order expectations to a queue      |
// |               that is popped whenever oen is seen.                         |
// |               FFT_REORDER_BYPASS_EN additionally runs a bypass frame.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_reorder_ctrl;

  localparam int N  = 3;
  localparam int MW = 18;
  localparam int DW = 2*MW;
  localparam int FL = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ien = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          byp_drv = 1'b0;
  logic          iready;
  logic          oen;
  logic [N-1:0]  oaddr;
  logic [DW-1:0] odata;
  logic          osof;

  always #5 clk = ~clk;

  fft_reorder_ctrl #(
    .TOTAL_STAGE_P (N),
    .MULT_WIDTH_P  (MW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ien     (ien),
    .idata   (idata),
`ifdef FFT_REORDER_BYPASS_EN
    .ibypass (byp_drv),
`endif
    .iready  (iready),
    .oen     (oen),
    .oaddr   (oaddr),
    .odata   (odata),
    .osof    (osof)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  addr;
    logic          sof;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] fbuf [FL];
  int            fcnt = 0;
  logic          mbyp = 1'b0;

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < N; b++) begin
      if ((k >> b) & 1) r = r | (1 << (N-1-b));
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        fcnt = 0;
        sbq.delete();
      end else if (ien && iready) begin
        if (fcnt == 0) mbyp = byp_drv;
        fbuf[fcnt] = idata;
        fcnt++;
        if (fcnt == FL) begin
          for (int k = 0; k < FL; k++) begin
            exp_t e;
            e.data = mbyp ? fbuf[k] : fbuf[rev(k)];
            e.addr = N'(k);
            e.sof  = (k == 0);
            sbq.push_back(e);
          end
          fcnt = 0;
        end
      end
    end
  end

  // Output monitor, sampling on the falling edge.
  int osof_cnt = 0;
  int oen_cnt  = 0;
  int run_len  = 0;
  int max_run  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && oen) begin
        oen_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (osof) osof_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_oen", 64'(oen), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_odata", 64'(odata), 64'(e.data));
          chk("sb_oaddr", 64'(oaddr), 64'(e.addr));
          chk("sb_osof",  64'(osof),  64'(e.sof));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] d);
    bit ok;
    bit acc;
    ok    = 1'b0;
    ien   = 1'b1;
    idata = d;
    for (int t = 0; t < 100; t++) begin
      acc = iready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    ien = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0 && !oen) break;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int v);
    return {MW'(v + 'h100), MW'(v)};
  endfunction

  // ---------------- test vector table for the basic frame ----------------
  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic [N-1:0]  exp_addr;
    logic          exp_sof;
  } vec_t;

  vec_t tbl [FL];
  int   exp_order [FL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    int osof0;
    int oen0;

    for (int i = 0; i < FL; i++) begin
      tbl[i].din      = DW'(i);
      tbl[i].exp_dout = DW'(exp_order[i]);
      tbl[i].exp_addr = N'(i);
      tbl[i].exp_sof  = (i == 0);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", 64'(iready), 64'd1);
    chk("rst_oen",    64'(oen),    64'd0);
    chk("rst_oaddr",  64'(oaddr),  64'd0);
    chk("rst_odata",  64'(odata),  64'd0);
    chk("rst_osof",   64'(osof),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame 0..7, latency and natural-order readout
    for (int i = 0; i < FL; i++) send(tbl[i].din);
    chk("lat_e0_oen", 64'(oen), 64'd0);
    @(posedge clk); #1;
    chk("lat_e1_oen", 64'(oen), 64'd0);
    @(posedge clk); #1;
    chk("lat_e2_oen", 64'(oen), 64'd1);
    for (int i = 0; i < FL; i++) begin
      chk("tbl_oen",   64'(oen),   64'd1);
      chk("tbl_odata", 64'(odata), 64'(tbl[i].exp_dout));
      chk("tbl_oaddr", 64'(oaddr), 64'(tbl[i].exp_addr));
      chk("tbl_osof",  64'(osof),  64'(tbl[i].exp_sof));
      @(posedge clk); #1;
    end
    chk("tbl_end_oen", 64'(oen), 64'd0);
    drain();

    // Three continuous frames
    osof0   = osof_cnt;
    max_run = 0;
    for (int i = 0; i < 3*FL; i++) send(mk(100 + i));
    drain();
    chk("cont_sof_count", 64'(osof_cnt - osof0), 64'd3);
    chk("cont_gapless_16", 64'(max_run >= 2*FL), 64'd1);

    // Both banks full, dropped pulse, then a third frame
    for (int i = 0; i < 2*FL; i++) send(mk(200 + i));
    chk("bp_iready_low", 64'(iready), 64'd0);
    ien   = 1'b1;
    idata = mk('h3ff);
    @(posedge clk); #1;
    ien = 1'b0;
    chk("bp_iready_freed", 64'(iready), 64'd1);
    for (int i = 0; i < FL; i++) send(mk(300 + i));
    drain();

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(mk(400 + i));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    oen0 = oen_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_partial_no_out", 64'(oen_cnt - oen0), 64'd0);
    for (int i = 0; i < FL; i++) send(mk(500 + i));
    drain();

`ifdef FFT_REORDER_BYPASS_EN
    // Bypass frame passes through in arrival order
    byp_drv = 1'b1;
    for (int i = 0; i < FL; i++) send(DW'(i));
    byp_drv = 1'b0;
    drain();
`endif

    chk("final_queue_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
